load_store_unit: RTL

- Sits directly upstream of the 32x32 word memory (5-bit word address, combinational read, write on posedge clk when write_enable is high) and is its only master.
- Converts byte-addressed byte/half/word load/store requests from the core into word accesses.
- Loads: extracts the lane, then sign- or zero-extends it.
- Sub-word stores: read-modify-write inside a single access cycle.
- Misaligned or reserved-size requests are rejected with an error response and never touch memory.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and the alignment rule used to reject requests.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0, the reserved size is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit (little-endian).
// Ports:
//   word        in  32  current memory word
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size encoding
//   is_unsigned in  1   loads: 1=zero-extend, 0=sign-extend
//   wdata       in  32  right-aligned store data
//   load_data   out 32  extracted and extended load value
//   store_word  out 32  word with the addressed lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        store_word = word;
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        store_word = word;
        store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed byte/half/word requests into single
// word accesses on a 32x32 memory with combinational read. Sub-word stores
// are a read-modify-write within the one ACCESS cycle.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_we, req_size, req_unsigned    request kind
//   req_addr, req_wdata               byte address, right-aligned store data
//   resp_valid/resp_ready             response handshake
//   resp_rdata, resp_err              load result, misalign/reserved error
//   mem_address, mem_write_enable     word memory address and write strobe
//   mem_data_in, mem_data_out         memory write data / combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_t        state;
  logic              lat_we;
  logic              lat_unsigned;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;
  logic              in_access;

  lsu_lane_align u_align (
    .word        (mem_data_out),
    .addr_lo     (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Memory is only driven during ACCESS; rst gates it so a reset landing
  // mid-access can never commit a write on that edge.
  always_comb begin
    in_access        = (state == ST_ACCESS) && !rst;
    req_ready        = (state == ST_IDLE) && !rst;
    resp_valid       = (state == ST_RESP);
    mem_address      = in_access ? lat_addr[ADDR_W-1:2] : '0;
    mem_write_enable = in_access && lat_we;
    mem_data_in      = (in_access && lat_we) ? store_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ST_ACCESS;
              resp_err <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          resp_rdata <= lat_we ? '0 : load_data;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
